// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network blocks: FSM state encoding,
// default widths and a saturating increment.
package snn_pkg;

   typedef enum logic {IDLE, COUNT} dec_state_t;

   localparam int unsigned NEURON_IN_W  = 8;
   localparam int unsigned DEF_WIN_LOG2 = 8;
   localparam int unsigned DEF_CNT_W    = NEURON_IN_W;
   localparam int unsigned DEF_ISI_W    = NEURON_IN_W;

   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic        inc,
                                           input logic [31:0] max_val);
      if (inc && (val != max_val)) return val + 32'd1;
      return val;
   endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Readout bus of the spike decoder: rate handshake, ISI pulse and status flags.
interface spike_rate_decoder_if
   import snn_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned ISI_W = DEF_ISI_W
);
   logic [CNT_W-1:0] rate;
   logic             rate_valid;
   logic             rate_ready;
   logic [ISI_W-1:0] isi;
   logic             isi_valid;
   logic             sat;
   logic             drop;

   modport master (output rate, rate_valid, isi, isi_valid, sat, drop,
                   input  rate_ready);
   modport slave  (input  rate, rate_valid, isi, isi_valid, sat, drop,
                   output rate_ready);
endinterface

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for a spike train; a held-high input yields one event.
module spike_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic spike_in,
   output logic ev
);
   logic spike_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) spike_d <= 1'b0;
      else       spike_d <= spike_in;
   end

   assign ev = spike_in & ~spike_d;
endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a spike train into a per-window spike rate (with valid/ready) and the
// latest inter-spike interval.
module spike_rate_decoder
   import snn_pkg::*;
#(
   parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2,
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned ISI_W    = DEF_ISI_W
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 clear,
   input  logic                 spike_in,
   spike_rate_decoder_if.master bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [ISI_W-1:0] ISI_MAX = '1;

   dec_state_t          state, state_next;
   logic                active, ev, close;
   logic [WIN_LOG2-1:0] win_cnt;
   logic [CNT_W-1:0]    spike_cnt, spike_sum, rate_q;
   logic [ISI_W-1:0]    isi_cnt, isi_q;
   logic                armed, rate_valid_q, isi_valid_q, sat_q, drop_q;

   spike_edge_detect u_edge (
      .clk      (clk),
      .reset    (reset),
      .spike_in (spike_in),
      .ev       (ev)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      state <= IDLE;
      else if (clear) state <= IDLE;
      else            state <= state_next;
   end

   always_comb begin
      state_next = enable ? COUNT : IDLE;
   end

   // Counting also stops in the cycle enable falls, so a partial window never closes.
   always_comb begin
      active = (state == COUNT) && enable;
   end

   assign close     = (win_cnt == '1);
   assign spike_sum = CNT_W'(sat_inc(32'(spike_cnt), ev, 32'(CNT_MAX)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset || clear) begin
         win_cnt      <= '0;
         spike_cnt    <= '0;
         isi_cnt      <= '0;
         armed        <= 1'b0;
         rate_q       <= '0;
         rate_valid_q <= 1'b0;
         isi_q        <= '0;
         isi_valid_q  <= 1'b0;
         sat_q        <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         isi_valid_q <= 1'b0;
         // Handshake runs in IDLE too; a close below overrides the release.
         if (rate_valid_q && bus.rate_ready) rate_valid_q <= 1'b0;
         if (!active) begin
            win_cnt   <= '0;
            spike_cnt <= '0;
            isi_cnt   <= '0;
            armed     <= 1'b0;
         end else begin
            win_cnt <= win_cnt + 1'b1;
            if (ev && (spike_cnt == CNT_MAX)) sat_q <= 1'b1;
            if (close) begin
               rate_q       <= spike_sum;
               spike_cnt    <= '0;
               rate_valid_q <= 1'b1;
               if (rate_valid_q && !bus.rate_ready) drop_q <= 1'b1;
            end else begin
               spike_cnt <= spike_sum;
            end
            if (ev) begin
               armed   <= 1'b1;
               isi_cnt <= ISI_W'(1);
               if (armed) begin
                  isi_q       <= isi_cnt;
                  isi_valid_q <= 1'b1;
               end
            end else if (armed) begin
               isi_cnt <= ISI_W'(sat_inc(32'(isi_cnt), 1'b1, 32'(ISI_MAX)));
            end
         end
      end
   end

   assign bus.rate       = rate_q;
   assign bus.rate_valid = rate_valid_q;
   assign bus.isi        = isi_q;
   assign bus.isi_valid  = isi_valid_q;
   assign bus.sat        = sat_q;
   assign bus.drop       = drop_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: two instances with 16-cycle windows,
// one with an 8-bit and one with a 3-bit rate counter.
module tb_spike_rate_decoder;
   logic clk = 1'b0;
   logic reset, enable, clear, spike_in;
   logic enable_b, clear_b, spike_b;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   seen;

   always #5 clk = ~clk;

   spike_rate_decoder_if #(.CNT_W(8), .ISI_W(8)) bus_a ();
   spike_rate_decoder_if #(.CNT_W(3), .ISI_W(8)) bus_b ();

   spike_rate_decoder #(.WIN_LOG2(4), .CNT_W(8), .ISI_W(8)) dut_a (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .clear    (clear),
      .spike_in (spike_in),
      .bus      (bus_a)
   );

   spike_rate_decoder #(.WIN_LOG2(4), .CNT_W(3), .ISI_W(8)) dut_b (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable_b),
      .clear    (clear_b),
      .spike_in (spike_b),
      .bus      (bus_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; clear = 1'b0; spike_in = 1'b0;
      enable_b = 1'b0; clear_b = 1'b0; spike_b = 1'b0;
      bus_a.rate_ready = 1'b1;
      bus_b.rate_ready = 1'b1;
      tick();
      tick();
      check("rst_rate", bus_a.rate, 0);
      check("rst_rate_valid", bus_a.rate_valid, 0);
      check("rst_isi", bus_a.isi, 0);
      check("rst_isi_valid", bus_a.isi_valid, 0);
      check("rst_sat", bus_a.sat, 0);
      check("rst_drop", bus_a.drop, 0);
      reset = 1'b0;

      // Spike every 4 cycles: rate 4 per window, isi 4
      enable = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) begin
         spike_in = (i % 4 == 0);
         tick();
         if (i == 4) begin
            check("per4_isi", bus_a.isi, 4);
            check("per4_isi_valid", bus_a.isi_valid, 1);
         end
         if (i == 5) check("per4_isi_pulse_end", bus_a.isi_valid, 0);
         if (i == 15 || i == 31) begin
            check("per4_rate", bus_a.rate, 4);
            check("per4_rate_valid", bus_a.rate_valid, 1);
            check("per4_sat", bus_a.sat, 0);
            check("per4_drop", bus_a.drop, 0);
         end
         if (i == 16) check("per4_accept", bus_a.rate_valid, 0);
      end
      spike_in = 1'b0; enable = 1'b0;
      tick();
      pulse_clear();

      // Held-high input counts once
      enable = 1'b1;
      tick();
      seen = 0;
      for (int i = 0; i < 48; i++) begin
         spike_in = (i >= 2);
         tick();
         if (bus_a.isi_valid) seen++;
         if (i == 15) begin
            check("hold_rate_w1", bus_a.rate, 1);
            check("hold_valid_w1", bus_a.rate_valid, 1);
         end
         if (i == 31) begin
            check("hold_rate_w2", bus_a.rate, 0);
            check("hold_valid_w2", bus_a.rate_valid, 1);
         end
         if (i == 47) check("hold_rate_w3", bus_a.rate, 0);
      end
      check("hold_no_isi", seen, 0);
      spike_in = 1'b0; enable = 1'b0;
      tick();
      pulse_clear();

      // 3-bit counter with 8 edges per window saturates at 7
      enable_b = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) begin
         spike_b = (i % 2 == 0);
         tick();
         if (i == 13) check("sat_before", bus_b.sat, 0);
         if (i == 14) check("sat_set", bus_b.sat, 1);
         if (i == 15) begin
            check("sat_rate_w1", bus_b.rate, 7);
            check("sat_valid_w1", bus_b.rate_valid, 1);
         end
         if (i == 31) begin
            check("sat_rate_w2", bus_b.rate, 7);
            check("sat_sticky", bus_b.sat, 1);
         end
      end
      spike_b = 1'b0;
      clear_b = 1'b1;
      tick();
      clear_b = 1'b0;
      check("sat_cleared", bus_b.sat, 0);
      check("sat_clr_valid", bus_b.rate_valid, 0);
      check("sat_clr_rate", bus_b.rate, 0);
      enable_b = 1'b0;
      tick();

      // Two closes without ready: 3 then 5 spikes, second overwrites
      bus_a.rate_ready = 1'b0;
      enable = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) begin
         spike_in = (i % 2 == 1) && ((i < 6) || (i >= 17 && i < 26));
         tick();
         if (i == 15) begin
            check("drop_rate_w1", bus_a.rate, 3);
            check("drop_valid_w1", bus_a.rate_valid, 1);
            check("drop_flag_w1", bus_a.drop, 0);
         end
         if (i == 31) begin
            check("drop_rate_w2", bus_a.rate, 5);
            check("drop_valid_w2", bus_a.rate_valid, 1);
            check("drop_flag_w2", bus_a.drop, 1);
         end
      end
      spike_in = 1'b0; enable = 1'b0; bus_a.rate_ready = 1'b1;
      tick();
      check("drop_accept_valid", bus_a.rate_valid, 0);
      check("drop_accept_rate", bus_a.rate, 5);
      check("drop_sticky", bus_a.drop, 1);
      pulse_clear();
      check("drop_cleared", bus_a.drop, 0);

      // Close coinciding with ready: no drop, valid stays high
      bus_a.rate_ready = 1'b0;
      enable = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) begin
         spike_in = (i == 2 || i == 4 || i == 20);
         bus_a.rate_ready = (i == 31);
         tick();
         if (i == 15) begin
            check("coin_rate_w1", bus_a.rate, 2);
            check("coin_valid_w1", bus_a.rate_valid, 1);
         end
         if (i == 31) begin
            check("coin_rate_w2", bus_a.rate, 1);
            check("coin_valid_w2", bus_a.rate_valid, 1);
            check("coin_drop", bus_a.drop, 0);
         end
      end
      spike_in = 1'b0; enable = 1'b0; bus_a.rate_ready = 1'b1;
      tick();
      check("coin_accept", bus_a.rate_valid, 0);
      pulse_clear();

      // Async reset mid-window at win_cnt 9 after 2 spikes
      enable = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) begin
         spike_in = (i == 2 || i == 5);
         tick();
      end
      check("pre_rst_isi", bus_a.isi, 3);
      #2;
      reset = 1'b1;
      #1;
      check("async_isi", bus_a.isi, 0);
      check("async_isi_valid", bus_a.isi_valid, 0);
      check("async_rate", bus_a.rate, 0);
      check("async_rate_valid", bus_a.rate_valid, 0);
      spike_in = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < 22; i++) begin
         spike_in = (i == 3 || i == 7 || i == 17);
         tick();
         if (i == 15) begin
            check("post_rst_rate", bus_a.rate, 2);
            check("post_rst_valid", bus_a.rate_valid, 1);
         end
         if (i == 16) check("post_rst_accept", bus_a.rate_valid, 0);
      end

      // enable drop mid-window: no rate, ISI disarmed
      spike_in = 1'b0; enable = 1'b0;
      tick();
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus_a.rate_valid || bus_a.isi_valid) seen++;
      end
      check("idle_no_output", seen, 0);
      enable = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         spike_in = (i == 2 || i == 6);
         tick();
         if (i == 2) check("disarm_first_spike", bus_a.isi_valid, 0);
         if (i == 6) begin
            check("rearm_isi", bus_a.isi, 4);
            check("rearm_isi_valid", bus_a.isi_valid, 1);
         end
      end
      spike_in = 1'b0; enable = 1'b0;
      tick();
      pulse_clear();

      // Spike on close cycle and ISI across the window boundary
      enable = 1'b1;
      tick();
      for (int i = 0; i < 32; i++) begin
         spike_in = (i == 15 || i == 19);
         tick();
         if (i == 15) begin
            check("edge_close_rate", bus_a.rate, 1);
            check("edge_close_valid", bus_a.rate_valid, 1);
         end
         if (i == 19) begin
            check("boundary_isi", bus_a.isi, 4);
            check("boundary_isi_valid", bus_a.isi_valid, 1);
         end
         if (i == 31) check("edge_next_rate", bus_a.rate, 1);
      end
      spike_in = 1'b0; enable = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
